// File: rtl/adder_pipe_para.sv
// Pipelined adder/subtractor: the WIDTH-bit carry chain is cut into STAGES equal
// segments with one register stage per segment, plus valid/ready flow control.
module adder_pipe_para #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("adder_pipe_para: STAGES must divide WIDTH and WIDTH must be >= 2");
  end

  // Handshake: a transfer happens on a clk edge where valid & ready are both 1.
  // in_ready depends combinationally on out_ready; out_* hold while out_valid & ~out_ready.
  logic [WIDTH-1:0]  beff;
  logic              c0;
  logic [STAGES-1:0] vld;
  logic [STAGES:0]   adv;

  assign beff = sub ? ~b : b;
  assign c0   = sub ? ~cin : cin;

  // adv[k] = ~vld[k] | adv[k+1] unrolled: a stage moves if the output drains or
  // any stage at or above it is empty.
  always_comb begin
    logic full;
    full        = 1'b1;
    adv         = '0;
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full   = full & vld[k];
      adv[k] = out_ready | ~full;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SEG;
    localparam int HI  = LO + SEG;
    localparam int REM = WIDTH - HI;

    logic           src_vld;
    logic [SEG-1:0] seg_a;
    logic [SEG-1:0] seg_b;
    logic           c_in;
    logic [SEG:0]   seg_sum;
    logic [HI-1:0]  sum_d;
    logic           load;
    logic           vld_q;
    logic           cy_q;
    logic [HI-1:0]  sum_q;

    if (k == 0) begin : g_src
      assign src_vld = in_valid;
      assign seg_a   = a[SEG-1:0];
      assign seg_b   = beff[SEG-1:0];
      assign c_in    = c0;
      assign sum_d   = seg_sum[SEG-1:0];
    end else begin : g_src
      assign src_vld = g_stage[k-1].vld_q;
      assign seg_a   = g_stage[k-1].g_rem.a_q[SEG-1:0];
      assign seg_b   = g_stage[k-1].g_rem.b_q[SEG-1:0];
      assign c_in    = g_stage[k-1].cy_q;
      assign sum_d   = {seg_sum[SEG-1:0], g_stage[k-1].sum_q};
    end

    assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, c_in};
    assign load    = adv[k] & src_vld;
    assign vld[k]  = vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else begin
        if (adv[k]) vld_q <= src_vld;
        if (load) begin
          cy_q  <= seg_sum[SEG];
          sum_q <= sum_d;
        end
      end
    end

    // Operand bits not yet consumed by a segment travel alongside the partial sum.
    if (REM > 0) begin : g_rem
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (k == 0) begin : g_rsrc
        assign a_d = a[WIDTH-1:HI];
        assign b_d = beff[WIDTH-1:HI];
      end else begin : g_rsrc
        assign a_d = g_stage[k-1].g_rem.a_q[REM+SEG-1:SEG];
        assign b_d = g_stage[k-1].g_rem.b_q[REM+SEG-1:SEG];
      end

      always_ff @(posedge clk) begin
        if (load) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_out
      logic ovf_q;

      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (load) begin
          ovf_q <= seg_a[SEG-1] ^ seg_b[SEG-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];
        end
      end

      assign s    = sum_q;
      assign cout = cy_q;
      assign ovf  = ovf_q;
    end
  end

endmodule

// File: doc/adder_pipe_para.md
Name: adder_pipe_para

Overview:
- Parametrised pipelined adder/subtractor. It is the registered successor of the ripple full-adder array.
- The WIDTH-bit carry chain is split into STAGES equal segments, with one pipeline register stage per segment. This removes the full-width ripple path from a single cycle.
- Supports add/subtract per transaction, a signed overflow flag, and valid/ready flow control with per-stage bubble collapsing.
- Sits in datapaths feeding accumulators and address generators where timing closure requires a registered carry.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 2.
- STAGES, 4, number of pipeline stages and carry segments. Must divide WIDTH exactly; elaboration fails otherwise. STAGES=1 gives a single registered full-width adder.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block accepts a transaction this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in when sub=0; borrow-in when sub=1.
- sub  input  1  0: s = a + b + cin; 1: s = a - b - cin.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  raw carry out of the MSB. For subtract, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All stage valid bits clear; out_valid=0.
  - s, cout, ovf = 0.
  - in_ready=1 in the first cycle after reset.
  - Data registers need not be cleared except the output stage.
  - Reset mid-operation discards all in-flight transactions; nothing is emitted for them.
- Acceptance:
  - A transaction is accepted when in_valid & in_ready at a clk edge.
  - Outputs are stable while out_valid=1 and out_ready=0.
  - A result is consumed when out_valid & out_ready.
- Operand conditioning at entry:
  - beff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
- Segment width SEG = WIDTH/STAGES. Stage k (0..STAGES-1):
  - Adds bits [k*SEG +: SEG] of a and beff, plus the carry registered by stage k-1 (c0 for k=0).
  - Registers the segment sum, the segment carry-out, all already-computed lower sum bits, and the still-unused upper a/beff bits.
- Stage STAGES-1 is the output register:
  - cout = final segment carry.
  - ovf = carry into MSB XOR carry out of MSB.
- Latency: a result appears on out_valid exactly STAGES cycles after acceptance when no backpressure is applied. Throughput is 1 transaction per cycle.
- Flow control (bubble collapsing):
  - stage_adv[k] = ~valid[k] | stage_adv[k+1], where stage_adv[STAGES] = out_ready.
  - in_ready = stage_adv[0].
  - A stage holds its contents when it cannot advance.
  - Bubbles are squeezed out while the output is stalled, so up to STAGES transactions can be held.
- Simultaneous accept and consume in one cycle: both happen; there is no loss and no duplication.
- Ordering: results emerge strictly in acceptance order.
- Full pipe with out_ready=0:
  - in_ready=0.
  - in_valid is ignored; a/b/cin/sub may change freely without effect.
- Arithmetic rules:
  - All results are modulo 2^WIDTH.
  - Signed overflow is detected for add and subtract alike.
  - ovf is valid only when out_valid=1, but is held stable with s.

Test Plan (WIDTH=16, STAGES=4):
- Reset, then single add:
  - Stimulus: a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1.
  - Required: out_valid rises exactly 4 cycles after acceptance with s=0x0100, cout=0, ovf=0. All outputs are 0 during reset.
- Full carry ripple across every segment:
  - Stimulus: a=0xFFFF, b=0x0000, cin=1.
  - Required: s=0x0000, cout=1, ovf=0.
- Subtract:
  - Stimulus 1: a=0x0005, b=0x0007, sub=1, cin=0.
  - Required 1: s=0xFFFE, cout=0 (borrow), ovf=0.
  - Stimulus 2: a=0x8000, b=0x0001, sub=1.
  - Required 2: s=0x7FFF, ovf=1.
- Back-to-back stream with backpressure:
  - Stimulus: 10 consecutive adds (a=i, b=i). Hold out_ready=0 for cycles 3..9.
  - Required: in_ready drops after 4 transactions are held, and results 0,2,4,…,18 are delivered in order with none lost or duplicated.
- Simultaneous accept and consume:
  - Stimulus: pipe full, out_ready=1, in_valid=1.
  - Required: in_ready=1, exactly one result leaves and one operand enters per cycle.
- Reset mid-flight:
  - Stimulus: assert rst with 3 transactions in flight.
  - Required: out_valid=0 the next cycle and none of the 3 results ever appear. A subsequent add of 0x1234+0x1111 yields s=0x2345.
